nf10_axis_memcached_streamout: RTL

Downstream drain stage for the memcached packet stream buffer. On a start request it reads WC words from the buffer's 64-bit read port, addresses 0..WC-1, and emits them as one 64-bit AXI4-Stream master packet. It hides the buffer's one-cycle registered-address read latency and sustains 1 beat/cycle under TREADY back-pressure. It sits between the stream buffer and the nf10 output arbiter/port.

---
 rtl/nf10_axis_memcached_streamout_pkg.sv | 31 +++
 rtl/nf10_axis_memcached_streamout_if.sv | 51 +++++
 rtl/nf10_axis_memcached_streamout_outreg.sv | 68 ++++++
 rtl/nf10_axis_memcached_streamout.sv | 137 +++++++++++++
 4 files changed

// File: rtl/nf10_axis_memcached_streamout_pkg.sv
// Shared types and constants for the memcached stream-out drain stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, AXIS widths, all-bytes TSTRB constant and a
// popcount helper used for the optional TUSER byte length
// (macro NF10_MEMCACHED_STREAMOUT_TUSER_EN).
package nf10_axis_memcached_pkg;

  localparam int AXIS_DATA_W  = 64;
  localparam int AXIS_STRB_W  = 8;
  localparam int AXIS_TUSER_W = 128;

  localparam logic [AXIS_STRB_W-1:0] TSTRB_ALL = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/nf10_axis_memcached_streamout_if.sv
// Bundle of the start request, buffer read port and AXIS master signals.
// Latency: n/a (wires only).
// Backpressure: n/a; M_AXIS_TREADY travels slave -> master.
// Modports: master = the stream-out block, slave = controller/buffer/sink side.
// With NF10_MEMCACHED_STREAMOUT_TUSER_EN defined, start_tuser and
// M_AXIS_TUSER are added.
interface nf10_axis_memcached_streamout_if #(
  parameter int WC_WIDTH = 8
);
  import nf10_axis_memcached_pkg::*;

  logic                    start;
  logic                    start_ready;
  logic [WC_WIDTH:0]       start_wc;
  logic [AXIS_STRB_W-1:0]  start_last_strb;
  logic                    done;
  logic [WC_WIDTH-1:0]     rd64_addr;
  logic [AXIS_DATA_W-1:0]  rd64_data;
  logic [AXIS_DATA_W-1:0]  M_AXIS_TDATA;
  logic [AXIS_STRB_W-1:0]  M_AXIS_TSTRB;
  logic                    M_AXIS_TLAST;
  logic                    M_AXIS_TVALID;
  logic                    M_AXIS_TREADY;
`ifdef NF10_MEMCACHED_STREAMOUT_TUSER_EN
  logic [AXIS_TUSER_W-1:0] start_tuser;
  logic [AXIS_TUSER_W-1:0] M_AXIS_TUSER;

  modport master (
    input  start, start_wc, start_last_strb, start_tuser, rd64_data, M_AXIS_TREADY,
    output start_ready, done, rd64_addr,
           M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_TVALID, M_AXIS_TUSER
  );
  modport slave (
    output start, start_wc, start_last_strb, start_tuser, rd64_data, M_AXIS_TREADY,
    input  start_ready, done, rd64_addr,
           M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_TVALID, M_AXIS_TUSER
  );
`else
  modport master (
    input  start, start_wc, start_last_strb, rd64_data, M_AXIS_TREADY,
    output start_ready, done, rd64_addr,
           M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_TVALID
  );
  modport slave (
    output start, start_wc, start_last_strb, rd64_data, M_AXIS_TREADY,
    input  start_ready, done, rd64_addr,
           M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_TVALID
  );
`endif

endinterface

// File: rtl/nf10_axis_memcached_streamout_outreg.sv
// AXIS output register: captures one beat on i_load, drops valid on handshake.
// Latency: 1 cycle from i_load to o_valid/o_data.
// Backpressure: holds data/strb/last stable while o_valid & !i_ready.
// Ports: clk/rst, i_load + beat fields in, i_ready from sink,
// o_valid/o_data/o_strb/o_last (+o_tuser with NF10_MEMCACHED_STREAMOUT_TUSER_EN).
module nf10_axis_memcached_streamout_outreg
  import nf10_axis_memcached_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic [AXIS_DATA_W-1:0] i_data,
  input  logic [AXIS_STRB_W-1:0] i_strb,
  input  logic                   i_last,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [AXIS_DATA_W-1:0] o_data,
  output logic [AXIS_STRB_W-1:0] o_strb,
  output logic                   o_last
`ifdef NF10_MEMCACHED_STREAMOUT_TUSER_EN
  ,
  input  logic [AXIS_TUSER_W-1:0] i_tuser,
  output logic [AXIS_TUSER_W-1:0] o_tuser
`endif
);

  logic                   r_valid;
  logic [AXIS_DATA_W-1:0] r_data;
  logic [AXIS_STRB_W-1:0] r_strb;
  logic                   r_last;

  // The caller only asserts i_load when the register is empty or draining
  // this cycle, so a load never overwrites an unaccepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_strb  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_strb  <= i_strb;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

`ifdef NF10_MEMCACHED_STREAMOUT_TUSER_EN
  logic [AXIS_TUSER_W-1:0] r_tuser;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tuser <= '0;
    end else if (i_load) begin
      r_tuser <= i_tuser;
    end
  end
  assign o_tuser = r_tuser;
`endif

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_strb  = r_strb;
  assign o_last  = r_last;

endmodule

// File: rtl/nf10_axis_memcached_streamout.sv
// Drains words 0..WC-1 of the packet buffer as one 64-bit AXIS packet per start.
// Latency: start accepted in cycle 0 -> first TVALID in cycle 2, then 1 beat/cycle.
// Backpressure: TREADY low holds the output beat and the buffer read address.
// Ports: ACLK/ARESET (async, active-high); bus (master modport) carries
// start/start_ready/start_wc/start_last_strb/done, rd64_addr/rd64_data and
// M_AXIS_*. Optional TUSER via macro NF10_MEMCACHED_STREAMOUT_TUSER_EN.
module nf10_axis_memcached_streamout
  import nf10_axis_memcached_pkg::*;
#(
  parameter int WC_MAX   = 190,
  parameter int WC_WIDTH = 8
) (
  input  logic ACLK,
  input  logic ARESET,
  nf10_axis_memcached_streamout_if.master bus
);

  localparam logic [WC_WIDTH:0]   WC_MAX_C  = (WC_WIDTH+1)'(WC_MAX);
  localparam logic [WC_WIDTH-1:0] ADDR_LAST = WC_WIDTH'(WC_MAX - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WC_WIDTH-1:0]    r_idx;       // index of the word now on rd64_data
  logic [WC_WIDTH:0]      r_wc;
  logic [AXIS_STRB_W-1:0] r_strb;
  logic                   r_zero_done;

  logic [WC_WIDTH-1:0]    w_addr;
  logic [WC_WIDTH:0]      w_eff_wc;
  logic [AXIS_STRB_W-1:0] w_eff_strb;
  logic                   w_accept;
  logic                   w_fill;
  logic                   w_load;
  logic                   w_is_last;
  logic                   w_valid;
  logic                   w_last;
  logic                   w_hs;

  assign w_accept   = bus.start & (r_state == S_IDLE);
  assign w_eff_wc   = (bus.start_wc > WC_MAX_C) ? WC_MAX_C : bus.start_wc;
  assign w_eff_strb = (bus.start_last_strb == '0) ? TSTRB_ALL : bus.start_last_strb;

  // FETCH and RUN are exactly the states with words still to load.
  assign w_fill    = (r_state == S_FETCH) | (r_state == S_RUN);
  assign w_load    = (~w_valid | bus.M_AXIS_TREADY) & w_fill;
  assign w_is_last = ({1'b0, r_idx} == (r_wc - 1'b1));
  assign w_hs      = w_valid & bus.M_AXIS_TREADY;

  always_comb begin
    w_state_nxt = r_state;
    w_addr      = r_idx;
    case (r_state)
      S_IDLE: begin
        w_addr = '0;
        if (w_accept && (w_eff_wc != '0)) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH, S_RUN: begin
        if (w_load) begin
          // Point the buffer at the next word; never step past the last slot.
          if (r_idx != ADDR_LAST) begin
            w_addr = r_idx + 1'b1;
          end
          w_state_nxt = w_is_last ? S_DRAIN : S_RUN;
        end
      end
      S_DRAIN: begin
        if (w_hs && w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_wc        <= '0;
      r_strb      <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_addr;
      r_zero_done <= w_accept && (w_eff_wc == '0);
      if (w_accept) begin
        r_wc   <= w_eff_wc;
        r_strb <= w_eff_strb;
      end
    end
  end

`ifdef NF10_MEMCACHED_STREAMOUT_TUSER_EN
  logic [AXIS_TUSER_W-1:0] r_tuser;
  logic [15:0]             w_len;

  // Byte length: full words before the last plus the bytes of the last one.
  assign w_len = ((16'(w_eff_wc) - 16'd1) << 3) + 16'(popcount8(w_eff_strb));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_tuser <= '0;
    end else if (w_accept) begin
      r_tuser <= {bus.start_tuser[AXIS_TUSER_W-1:16],
                  (bus.start_tuser[15:0] == 16'd0) ? w_len : bus.start_tuser[15:0]};
    end
  end
`endif

  nf10_axis_memcached_streamout_outreg u_outreg (
    .clk     (ACLK),
    .rst     (ARESET),
    .i_load  (w_load),
    .i_data  (bus.rd64_data),
    .i_strb  (w_is_last ? r_strb : TSTRB_ALL),
    .i_last  (w_is_last),
    .i_ready (bus.M_AXIS_TREADY),
    .o_valid (w_valid),
    .o_data  (bus.M_AXIS_TDATA),
    .o_strb  (bus.M_AXIS_TSTRB),
    .o_last  (w_last)
`ifdef NF10_MEMCACHED_STREAMOUT_TUSER_EN
    ,
    .i_tuser ((r_idx == '0) ? r_tuser : '0),
    .o_tuser (bus.M_AXIS_TUSER)
`endif
  );

  assign bus.M_AXIS_TVALID = w_valid;
  assign bus.M_AXIS_TLAST  = w_last;
  assign bus.rd64_addr     = w_addr;
  assign bus.start_ready   = (r_state == S_IDLE);
  assign bus.done          = r_zero_done | ((r_state == S_DRAIN) & w_hs & w_last);

endmodule
